// File: rtl/riscv_pkg.sv
// Shared register-file parameters and types.
// It also provides a one-hot decode helper used by the scoreboard.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0]     xlen_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic reg_vec_t reg_onehot(input reg_addr_t addr);
    reg_vec_t vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Decode/writeback-facing bundle of the register file.
// The master side is decode plus the writeback stage; the slave side is reg_file_wb.
interface reg_file_wb_if;

  riscv_pkg::reg_addr_t rs1_addr;
  riscv_pkg::reg_addr_t rs2_addr;
  riscv_pkg::xlen_t     rs1_data;
  riscv_pkg::xlen_t     rs2_data;
  logic                 issue_valid;
  logic                 use_rs1;
  logic                 use_rs2;
  logic                 issue_wr;
  riscv_pkg::reg_addr_t issue_rd;
  logic                 wb_en;
  riscv_pkg::reg_addr_t wb_addr;
  riscv_pkg::xlen_t     write_back_data_in;
  logic                 flush;
  logic                 stall;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, use_rs1, use_rs2, issue_wr, issue_rd,
           wb_en, wb_addr, write_back_data_in, flush,
    input  rs1_data, rs2_data, stall
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, use_rs1, use_rs2, issue_wr, issue_rd,
           wb_en, wb_addr, write_back_data_in, flush,
    output rs1_data, rs2_data, stall
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear/flush, and RAW/WAW stall generation.
// With REGFILE_BYPASS_EN, a register written back this cycle stops counting as busy.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      issue_valid_i,
  input  logic      use_rs1_i,
  input  logic      use_rs2_i,
  input  logic      issue_wr_i,
  input  reg_addr_t issue_rd_i,
  input  reg_addr_t rs1_addr_i,
  input  reg_addr_t rs2_addr_i,
  input  logic      wb_en_i,
  input  reg_addr_t wb_addr_i,
  input  logic      flush_i,
  output logic      stall_o
);

  reg_vec_t busy_q;
  reg_vec_t busy_d;
  reg_vec_t wbHit;
  reg_vec_t effBusy;
  logic     issueAccept;

  assign wbHit = wb_en_i ? reg_onehot(wb_addr_i) : '0;

`ifdef REGFILE_BYPASS_EN
  assign effBusy = busy_q & ~wbHit;
`else
  // Without write-through, the register being written this cycle still reads stale data.
  assign effBusy = busy_q | (wbHit & ~reg_onehot(REG_ZERO));
`endif

  assign stall_o = issue_valid_i & ((use_rs1_i & effBusy[rs1_addr_i])
                                  | (use_rs2_i & effBusy[rs2_addr_i])
                                  | (issue_wr_i & effBusy[issue_rd_i]));

  assign issueAccept = issue_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      // The clear is applied before the set so a same-cycle reissue keeps the bit.
      busy_d = busy_q & ~wbHit;
      if (issueAccept && issue_wr_i && (issue_rd_i != REG_ZERO)) begin
        busy_d[issue_rd_i] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file x0..x31 with two combinational read ports and a writeback port.
// REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
module reg_file_wb
  import riscv_pkg::*;
(
  input logic           clock,
  input logic           reset_n,
  reg_file_wb_if.slave  bus
);

  xlen_t regs_q [NUM_REGS];
  xlen_t rs1Data;
  xlen_t rs2Data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != REG_ZERO)) begin
      regs_q[bus.wb_addr] <= bus.write_back_data_in;
    end
  end

  always_comb begin
    rs1Data = regs_q[bus.rs1_addr];
    rs2Data = regs_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == bus.rs1_addr)) begin
      rs1Data = bus.write_back_data_in;
    end
    if (bus.wb_en && (bus.wb_addr == bus.rs2_addr)) begin
      rs2Data = bus.write_back_data_in;
    end
`endif
    // x0 reads zero even if a bypass matched it.
    if (bus.rs1_addr == REG_ZERO) begin
      rs1Data = '0;
    end
    if (bus.rs2_addr == REG_ZERO) begin
      rs2Data = '0;
    end
  end

  assign bus.rs1_data = rs1Data;
  assign bus.rs2_data = rs2Data;

  reg_scoreboard u_scoreboard (
    .clock         (clock),
    .reset_n       (reset_n),
    .issue_valid_i (bus.issue_valid),
    .use_rs1_i     (bus.use_rs1),
    .use_rs2_i     (bus.use_rs2),
    .issue_wr_i    (bus.issue_wr),
    .issue_rd_i    (bus.issue_rd),
    .rs1_addr_i    (bus.rs1_addr),
    .rs2_addr_i    (bus.rs2_addr),
    .wb_en_i       (bus.wb_en),
    .wb_addr_i     (bus.wb_addr),
    .flush_i       (bus.flush),
    .stall_o       (bus.stall)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_wb;

  logic clock;
  logic reset_n;
  int   testsRun;
  int   testsFailed;

  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rs1_addr           = '0;
    bus.rs2_addr           = '0;
    bus.issue_valid        = 1'b0;
    bus.use_rs1            = 1'b0;
    bus.use_rs2            = 1'b0;
    bus.issue_wr           = 1'b0;
    bus.issue_rd           = '0;
    bus.wb_en              = 1'b0;
    bus.wb_addr            = '0;
    bus.write_back_data_in = '0;
    bus.flush              = 1'b0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_wr    = 1'b1;
    bus.issue_rd    = rd;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL issue_rd%0d_stall: got %b expected 0", rd, bus.stall);
    end
    step();
    idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #2;
    for (int i = 1; i < 32; i++) begin
      bus.rs1_addr = i[4:0];
      bus.rs2_addr = i[4:0];
      #1;
      testsRun++;
      if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
        testsFailed++;
        $display("[TB] FAIL reset_read x%0d: got %h/%h expected 0", i, bus.rs1_data, bus.rs2_data);
      end
    end
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.rs1_addr    = 5'd1;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall);
    end
    idle();
    #1;
    reset_n = 1'b1;
    step();
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd5;
    bus.write_back_data_in = 32'hDEADBEEF;
    step();
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd5;
    #1;
    testsRun++;
    if (bus.rs1_data !== 32'hDEADBEEF || bus.rs2_data !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL write_x5: got %h/%h expected deadbeef", bus.rs1_data, bus.rs2_data);
    end
    idle();
  endtask

  task automatic test_x0();
    idle();
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd0;
    bus.write_back_data_in = 32'h12345678;
    bus.issue_valid        = 1'b1;
    bus.issue_wr           = 1'b1;
    bus.issue_rd           = 5'd0;
    bus.rs1_addr           = 5'd0;
    #1;
    testsRun++;
    if (bus.rs1_data !== 32'h0 || bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL x0_wb_cycle: got data %h stall %b expected 0/0", bus.rs1_data, bus.stall);
    end
    step();
    idle();
    bus.rs1_addr    = 5'd0;
    bus.rs2_addr    = 5'd0;
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.use_rs2     = 1'b1;
    bus.issue_wr    = 1'b1;
    bus.issue_rd    = 5'd0;
    #1;
    testsRun++;
    if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL x0_read: got %h/%h expected 0", bus.rs1_data, bus.rs2_data);
    end
    testsRun++;
    if (bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL x0_stall: got %b expected 0", bus.stall);
    end
    step();
    idle();
  endtask

  task automatic test_raw();
    logic expStall;
    logic [31:0] expData;
    issue_write(5'd7);
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.rs1_addr    = 5'd7;
    #1;
    testsRun++;
    if (bus.stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL raw_stall_first: got %b expected 1", bus.stall);
    end
    step();
    testsRun++;
    if (bus.stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL raw_stall_hold: got %b expected 1", bus.stall);
    end
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd7;
    bus.write_back_data_in = 32'hCAFEF00D;
`ifdef REGFILE_BYPASS_EN
    expStall = 1'b0;
    expData  = 32'hCAFEF00D;
`else
    expStall = 1'b1;
    expData  = 32'h0;
`endif
    #1;
    testsRun++;
    if (bus.stall !== expStall || bus.rs1_data !== expData) begin
      testsFailed++;
      $display("[TB] FAIL raw_wb_cycle: got stall %b data %h expected %b/%h",
               bus.stall, bus.rs1_data, expStall, expData);
    end
    step();
    bus.wb_en = 1'b0;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0 || bus.rs1_data !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("[TB] FAIL raw_after_wb: got stall %b data %h expected 0/cafef00d",
               bus.stall, bus.rs1_data);
    end
    idle();
  endtask

  task automatic test_waw();
    logic expStallSame;
    logic expStallAfter;
    issue_write(5'd9);
    bus.issue_valid = 1'b1;
    bus.issue_wr    = 1'b1;
    bus.issue_rd    = 5'd9;
    #1;
    testsRun++;
    if (bus.stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL waw_stall: got %b expected 1", bus.stall);
    end
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd9;
    bus.write_back_data_in = 32'h00000099;
`ifdef REGFILE_BYPASS_EN
    expStallSame  = 1'b0;
    expStallAfter = 1'b1;
`else
    expStallSame  = 1'b1;
    expStallAfter = 1'b0;
`endif
    #1;
    testsRun++;
    if (bus.stall !== expStallSame) begin
      testsFailed++;
      $display("[TB] FAIL set_wins_issue: got %b expected %b", bus.stall, expStallSame);
    end
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.use_rs2     = 1'b1;
    bus.rs2_addr    = 5'd9;
    #1;
    testsRun++;
    if (bus.stall !== expStallAfter) begin
      testsFailed++;
      $display("[TB] FAIL set_wins_reader: got %b expected %b", bus.stall, expStallAfter);
    end
    testsRun++;
    if (bus.rs2_data !== 32'h00000099) begin
      testsFailed++;
      $display("[TB] FAIL waw_data_x9: got %h expected 00000099", bus.rs2_data);
    end
    idle();
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd9;
    bus.write_back_data_in = 32'h00000099;
    step();
    idle();
  endtask

  task automatic test_flush();
    issue_write(5'd3);
    issue_write(5'd4);
    bus.flush              = 1'b1;
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd3;
    bus.write_back_data_in = 32'h33333333;
    bus.issue_valid        = 1'b1;
    bus.issue_wr           = 1'b1;
    bus.issue_rd           = 5'd5;
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.use_rs2     = 1'b1;
    bus.rs1_addr    = 5'd3;
    bus.rs2_addr    = 5'd4;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_clear: got %b expected 0", bus.stall);
    end
    testsRun++;
    if (bus.rs1_data !== 32'h33333333) begin
      testsFailed++;
      $display("[TB] FAIL flush_wb_x3: got %h expected 33333333", bus.rs1_data);
    end
    bus.use_rs2  = 1'b0;
    bus.rs1_addr = 5'd5;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_drops_issue: got %b expected 0", bus.stall);
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    bus.wb_en              = 1'b1;
    bus.wb_addr            = 5'd10;
    bus.write_back_data_in = 32'h0000A5A5;
    step();
    idle();
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.rs1_addr    = 5'd10;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0 || bus.rs1_data !== 32'h0000A5A5) begin
      testsFailed++;
      $display("[TB] FAIL wb_not_busy: got stall %b data %h expected 0/0000a5a5",
               bus.stall, bus.rs1_data);
    end
    issue_write(5'd10);
    bus.issue_valid = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.rs1_addr    = 5'd10;
    #1;
    testsRun++;
    if (bus.stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL async_pre_stall: got %b expected 1", bus.stall);
    end
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (bus.stall !== 1'b0 || bus.rs1_data !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got stall %b data %h expected 0/0", bus.stall, bus.rs1_data);
    end
    #1;
    reset_n = 1'b1;
    step();
    idle();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b0;
    idle();
    test_reset();
    test_x0();
    test_raw();
    test_waw();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
